// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write-side front end:
//   - default data / register-index widths
//   - wb_src_e   : identifies a writeback source (ALU or load/memory path)
//   - wb_entry_t : one buffered writeback {rd, data} at the default widths
//   - other_src  : the source opposite to a given one (round-robin helper)
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 64;
  localparam int DEFAULT_ADDRESS_WIDTH = 5;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [DEFAULT_ADDRESS_WIDTH-1:0] rd;
    logic [DEFAULT_DATA_WIDTH-1:0]    data;
  } wb_entry_t;

  // Round-robin: on a tie the source that did not win last time is chosen.
  function automatic wb_src_e other_src(input wb_src_e src);
    wb_src_e res;
    case (src)
      WB_SRC_ALU: res = WB_SRC_MEM;
      WB_SRC_MEM: res = WB_SRC_ALU;
      default:    res = WB_SRC_ALU;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO buffering one writeback source.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   push, push_data      : write an entry (ignored when full)
//   pop, pop_data        : remove the head entry (ignored when empty);
//                          pop_data always shows the current head
//   count                : number of stored entries, 0..DEPTH
//   full, empty          : decoded from the registered count
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == {CW{1'b0}});
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = storage[rd_ptr];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1'b1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1'b1);
        2'b01:   count <= count - CW'(1'b1);
        default: count <= count;  // idle, or push and pop together
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-side front end of the register file. ALU and load results arrive
// over valid/ready handshakes, are buffered per source, and are granted
// round-robin onto the register file's single write port.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data: ALU writeback handshake
//   mem_valid/mem_ready/mem_rd/mem_data: load writeback handshake
//   RegWrite, wa, wd                   : registered write port
//   idle                               : nothing buffered, no write pending
// Writes to x0 take a grant slot but never raise RegWrite; wa/wd then hold.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]    wd,
  output logic                     idle
);

  localparam int EW = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          alu_push, mem_push;
  logic          alu_pop, mem_pop;
  logic [EW-1:0] alu_head, mem_head, sel_head;
  logic [CW-1:0] alu_count, mem_count;
  logic          alu_full, mem_full;
  logic          alu_empty, mem_empty;

  logic                     grant;
  wb_src_e                  grant_src;
  wb_src_e                  last_grant;
  logic [ADDRESS_WIDTH-1:0] grant_rd;
  logic [DATA_WIDTH-1:0]    grant_data;

  // Ready comes only from the registered count (plus reset), so a pop in the
  // same cycle does not reopen a full FIFO until the following cycle.
  assign alu_ready = !reset && !alu_full;
  assign mem_ready = !reset && !mem_full;
  assign alu_push  = alu_valid && alu_ready;
  assign mem_push  = mem_valid && mem_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_alu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (alu_push),
    .push_data ({alu_rd, alu_data}),
    .pop       (alu_pop),
    .pop_data  (alu_head),
    .count     (alu_count),
    .full      (alu_full),
    .empty     (alu_empty)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_mem_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_push),
    .push_data ({mem_rd, mem_data}),
    .pop       (mem_pop),
    .pop_data  (mem_head),
    .count     (mem_count),
    .full      (mem_full),
    .empty     (mem_empty)
  );

  // Round-robin arbiter: a lone non-empty source wins; on a tie the source
  // not granted last time wins.
  always_comb begin
    grant     = 1'b0;
    grant_src = last_grant;
    case ({!alu_empty, !mem_empty})
      2'b10: begin
        grant     = 1'b1;
        grant_src = WB_SRC_ALU;
      end
      2'b01: begin
        grant     = 1'b1;
        grant_src = WB_SRC_MEM;
      end
      2'b11: begin
        grant     = 1'b1;
        grant_src = other_src(last_grant);
      end
      default: begin
        grant     = 1'b0;
        grant_src = last_grant;
      end
    endcase
  end

  assign alu_pop = grant && (grant_src == WB_SRC_ALU);
  assign mem_pop = grant && (grant_src == WB_SRC_MEM);

  // Select the head entry of the granted source.
  always_comb begin
    sel_head = alu_head;
    if (grant_src == WB_SRC_MEM) begin
      sel_head = mem_head;
    end else begin
      sel_head = alu_head;
    end
  end

  assign grant_rd   = sel_head[EW-1:DATA_WIDTH];
  assign grant_data = sel_head[DATA_WIDTH-1:0];

  // Registered write port and round-robin history. An x0 entry still counts
  // as a grant (it is popped and moves last_grant) but leaves wa/wd alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      wa         <= {ADDRESS_WIDTH{1'b0}};
      wd         <= {DATA_WIDTH{1'b0}};
      last_grant <= WB_SRC_ALU;
    end else if (grant) begin
      RegWrite   <= (grant_rd != {ADDRESS_WIDTH{1'b0}});
      last_grant <= grant_src;
      if (grant_rd != {ADDRESS_WIDTH{1'b0}}) begin
        wa <= grant_rd;
        wd <= grant_data;
      end
    end else begin
      RegWrite <= 1'b0;
    end
  end

  assign idle = (alu_count == {CW{1'b0}}) && (mem_count == {CW{1'b0}}) && !RegWrite;

endmodule
